// File: rtl/vreg_collect_pkg.sv
// Shared types and constants for the vector register group collector.
package vreg_collect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  localparam int unsigned MAX_GROUP = 8;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SIZE  = 2'd1;
  localparam logic [1:0] ERR_ORDER = 2'd2;
  localparam logic [1:0] ERR_LAST  = 2'd3;

  // A group holds 1, 2, 4 or 8 registers.
  function automatic logic legal_group_size(input logic [7:0] size);
    return (size == 8'd1) || (size == 8'd2) || (size == 8'd4) || (size == 8'd8);
  endfunction

endpackage

// File: rtl/vreg_group_buffer.sv
// Eight-slot register storage: synchronous clear-all plus one slot write per cycle.
module vreg_group_buffer
  import vreg_collect_pkg::*;
#(
  parameter int unsigned VLEN = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clr,
  input  logic                                we,
  input  logic [2:0]                          widx,
  input  logic [VLEN-1:0]                     wdata,
  output logic [MAX_GROUP-1:0][VLEN-1:0]      slots
);

  logic [MAX_GROUP-1:0][VLEN-1:0] slots_q, slots_d;

  // Clear first so a same-cycle write lands on top of the cleared buffer.
  always_comb begin
    slots_d = slots_q;
    if (clr) slots_d = '0;
    if (we)  slots_d[widx] = wdata;
  end

  // Slot storage register.
  always_ff @(posedge clk) begin
    if (reset) slots_q <= '0;
    else       slots_q <= slots_d;
  end

  assign slots = slots_q;

endmodule

// File: rtl/vreg_group_collector.sv
// Assembles per-register writeback beats into one complete group record.
module vreg_group_collector
  import vreg_collect_pkg::*;
#(
  parameter int unsigned VLEN = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_store,
  input  logic            in_wr_rf,
  input  logic [7:0]      in_rf_addr,
  input  logic [7:0]      in_group_size,
  input  logic [2:0]      in_idx,
  input  logic            in_last,
  input  logic [VLEN-1:0] in_data,
  output logic            out_enable,
  output logic            out_is_store,
  output logic            out_wr_rf,
  output logic [7:0]      out_rf_addr,
  output logic [7:0]      out_rf_group_size,
  output logic [VLEN-1:0] out_data_0,
  output logic [VLEN-1:0] out_data_1,
  output logic [VLEN-1:0] out_data_2,
  output logic [VLEN-1:0] out_data_3,
  output logic [VLEN-1:0] out_data_4,
  output logic [VLEN-1:0] out_data_5,
  output logic [VLEN-1:0] out_data_6,
  output logic [VLEN-1:0] out_data_7,
  output logic            err_pulse,
  output logic [1:0]      err_code
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_store_q, is_store_d;
  logic        wr_rf_q, wr_rf_d;
  logic [7:0]  rf_addr_q, rf_addr_d;
  logic [7:0]  size_q, size_d;
  logic        err_pulse_q, err_pulse_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        buf_clr, buf_we;
  logic [MAX_GROUP-1:0][VLEN-1:0] slots;

  logic        accept;
  logic        hdr_match;
  logic [3:0]  cnt_inc;
  logic        completes;

  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + 4'd1;
  assign completes = ({4'd0, cnt_inc} == in_group_size);
  assign hdr_match = (in_is_store == is_store_q) && (in_wr_rf == wr_rf_q) &&
                     (in_rf_addr == rf_addr_q) && (in_group_size == size_q);

  vreg_group_buffer #(
    .VLEN (VLEN)
  ) u_buffer (
    .clk   (clk),
    .reset (reset),
    .clr   (buf_clr),
    .we    (buf_we),
    .widx  (in_idx),
    .wdata (in_data),
    .slots (slots)
  );

  // Next-state, header latch and error classification.
  // Error beats never touch the header or slots; only a clean first beat clears them.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_store_d  = is_store_q;
    wr_rf_d     = wr_rf_q;
    rf_addr_d   = rf_addr_q;
    size_d      = size_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    buf_clr     = 1'b0;
    buf_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!legal_group_size(in_group_size)) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_SIZE;
          end else if (in_idx != 3'd0) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_ORDER;
          end else if (in_last != (in_group_size == 8'd1)) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_LAST;
          end else begin
            is_store_d = in_is_store;
            wr_rf_d    = in_wr_rf;
            rf_addr_d  = in_rf_addr;
            size_d     = in_group_size;
            buf_clr    = 1'b1;
            buf_we     = 1'b1;
            cnt_d      = 4'd1;
            state_d    = (in_group_size == 8'd1) ? ST_EMIT : ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (accept) begin
          if (!hdr_match || ({1'b0, in_idx} != cnt_q)) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_ORDER;
            cnt_d       = 4'd0;
            state_d     = ST_IDLE;
          end else if (in_last != completes) begin
            err_pulse_d = 1'b1;
            err_code_d  = ERR_LAST;
            cnt_d       = 4'd0;
            state_d     = ST_IDLE;
          end else begin
            buf_we = 1'b1;
            cnt_d  = cnt_inc;
            if (completes) state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, header and error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_store_q  <= 1'b0;
      wr_rf_q     <= 1'b0;
      rf_addr_q   <= '0;
      size_q      <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_store_q  <= is_store_d;
      wr_rf_q     <= wr_rf_d;
      rf_addr_q   <= rf_addr_d;
      size_q      <= size_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  // Handshake and record strobe decoded from the state register only.
  always_comb begin
    in_ready   = (state_q != ST_EMIT);
    out_enable = (state_q == ST_EMIT);
  end

  assign out_is_store      = is_store_q;
  assign out_wr_rf         = wr_rf_q;
  assign out_rf_addr       = rf_addr_q;
  assign out_rf_group_size = size_q;
  assign err_pulse         = err_pulse_q;
  assign err_code          = err_code_q;
  assign out_data_0        = slots[0];
  assign out_data_1        = slots[1];
  assign out_data_2        = slots[2];
  assign out_data_3        = slots[3];
  assign out_data_4        = slots[4];
  assign out_data_5        = slots[5];
  assign out_data_6        = slots[6];
  assign out_data_7        = slots[7];

endmodule

// File: tb/tb_vreg_group_collector.sv
// Directed bench for vreg_group_collector with a queue-based reference model.
module tb_vreg_group_collector;

  localparam int unsigned VLEN = 64;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic            in_is_store;
  logic            in_wr_rf;
  logic [7:0]      in_rf_addr;
  logic [7:0]      in_group_size;
  logic [2:0]      in_idx;
  logic            in_last;
  logic [VLEN-1:0] in_data;
  logic            out_enable;
  logic            out_is_store;
  logic            out_wr_rf;
  logic [7:0]      out_rf_addr;
  logic [7:0]      out_rf_group_size;
  logic [VLEN-1:0] out_data_0, out_data_1, out_data_2, out_data_3;
  logic [VLEN-1:0] out_data_4, out_data_5, out_data_6, out_data_7;
  logic            err_pulse;
  logic [1:0]      err_code;

  logic [VLEN-1:0] od [8];
  assign od[0] = out_data_0;
  assign od[1] = out_data_1;
  assign od[2] = out_data_2;
  assign od[3] = out_data_3;
  assign od[4] = out_data_4;
  assign od[5] = out_data_5;
  assign od[6] = out_data_6;
  assign od[7] = out_data_7;

  vreg_group_collector #(
    .VLEN (VLEN)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_is_store       (in_is_store),
    .in_wr_rf          (in_wr_rf),
    .in_rf_addr        (in_rf_addr),
    .in_group_size     (in_group_size),
    .in_idx            (in_idx),
    .in_last           (in_last),
    .in_data           (in_data),
    .out_enable        (out_enable),
    .out_is_store      (out_is_store),
    .out_wr_rf         (out_wr_rf),
    .out_rf_addr       (out_rf_addr),
    .out_rf_group_size (out_rf_group_size),
    .out_data_0        (out_data_0),
    .out_data_1        (out_data_1),
    .out_data_2        (out_data_2),
    .out_data_3        (out_data_3),
    .out_data_4        (out_data_4),
    .out_data_5        (out_data_5),
    .out_data_6        (out_data_6),
    .out_data_7        (out_data_7),
    .err_pulse         (err_pulse),
    .err_code          (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VLEN-1:0] dpat(input logic [7:0] tag, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {tag, kb, 48'h0123_4567_89AB};
  endfunction

  // Reference model: a group is a queue of accepted beats judged against the first beat.
  logic            m_ready = 1'b1;
  logic            m_en    = 1'b0;
  logic            m_errp  = 1'b0;
  logic [1:0]      m_code  = 2'd0;
  logic            m_st    = 1'b0;
  logic            m_wr    = 1'b0;
  logic [7:0]      m_addr  = '0;
  logic [7:0]      m_size  = '0;
  logic [VLEN-1:0] m_data [8];
  bit              m_valid_rec = 1'b1;
  logic            g_st, g_wr;
  logic [7:0]      g_addr, g_size;
  logic [VLEN-1:0] q [$];

  task automatic m_flag(input logic [1:0] c);
    m_errp = 1'b1;
    m_code = c;
    q.delete();
  endtask

  task automatic m_finish();
    m_en = 1'b1;
    m_ready = 1'b0;
    m_valid_rec = 1'b1;
    m_st = g_st;
    m_wr = g_wr;
    m_addr = g_addr;
    m_size = g_size;
    for (int k = 0; k < 8; k++) m_data[k] = (k < q.size()) ? q[k] : '0;
    q.delete();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) m_data[k] = '0;
    forever begin
      @(posedge clk);
      m_errp = 1'b0;
      if (reset) begin
        m_en = 1'b0;
        m_ready = 1'b1;
        m_code = 2'd0;
        m_st = 1'b0;
        m_wr = 1'b0;
        m_addr = '0;
        m_size = '0;
        for (int k = 0; k < 8; k++) m_data[k] = '0;
        q.delete();
        m_valid_rec = 1'b1;
      end else if (m_en) begin
        m_en = 1'b0;
        m_ready = 1'b1;
      end else if (in_valid) begin
        if (q.size() == 0) begin
          m_valid_rec = 1'b0;
          if (!(in_group_size inside {8'd1, 8'd2, 8'd4, 8'd8})) m_flag(2'd1);
          else if (in_idx != 3'd0) m_flag(2'd2);
          else if (in_last != (in_group_size == 8'd1)) m_flag(2'd3);
          else begin
            g_st = in_is_store;
            g_wr = in_wr_rf;
            g_addr = in_rf_addr;
            g_size = in_group_size;
            q.push_back(in_data);
            if (g_size == 8'd1) m_finish();
          end
        end else begin
          if (int'(in_idx) != q.size() || in_is_store != g_st || in_wr_rf != g_wr ||
              in_rf_addr != g_addr || in_group_size != g_size) m_flag(2'd2);
          else if (in_last != (q.size() + 1 == int'(g_size))) m_flag(2'd3);
          else begin
            q.push_back(in_data);
            if (q.size() == int'(g_size)) m_finish();
          end
        end
      end
    end
  end

  // Compare every cycle; record fields only when they carry a defined record.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", in_ready, m_ready);
      chk("out_enable", out_enable, m_en);
      chk("err_pulse", err_pulse, m_errp);
      chk("err_code", err_code, m_code);
      if (m_valid_rec) begin
        chk("out_is_store", out_is_store, m_st);
        chk("out_wr_rf", out_wr_rf, m_wr);
        chk("out_rf_addr", out_rf_addr, m_addr);
        chk("out_rf_group_size", out_rf_group_size, m_size);
        for (int k = 0; k < 8; k++) chk($sformatf("out_data_%0d", k), od[k], m_data[k]);
      end
    end
  end

  task automatic send(input logic st, input logic wr, input logic [7:0] addr, input logic [7:0] size,
                      input int idx, input logic last, input logic [VLEN-1:0] data, input int gap);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_wait actual=0 required=1 at %0t", $time);
    end
    in_valid = 1'b1;
    in_is_store = st;
    in_wr_rf = wr;
    in_rf_addr = addr;
    in_group_size = size;
    in_idx = 3'(idx);
    in_last = last;
    in_data = data;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_is_store = 1'b0;
    in_wr_rf = 1'b0;
    in_rf_addr = '0;
    in_group_size = '0;
    in_idx = '0;
    in_last = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data_0", out_data_0, '0);
    chk("rst_err_code", err_code, 2'd0);
    reset = 1'b0;
    @(negedge clk);

    // Size 1
    send(1'b0, 1'b1, 8'd5, 8'd1, 0, 1'b1, 64'hAAAA_5555_1234_0001, 0);
    chk("s1_enable", out_enable, 1'b1);
    chk("s1_data0", out_data_0, 64'hAAAA_5555_1234_0001);
    chk("s1_data1", out_data_1, '0);
    chk("s1_size", out_rf_group_size, 8'd1);
    chk("s1_addr", out_rf_addr, 8'd5);
    chk("s1_ready", in_ready, 1'b0);
    @(negedge clk);
    chk("s1_hold_data0", out_data_0, 64'hAAAA_5555_1234_0001);

    // Size 8 with idle gaps
    for (int k = 0; k < 8; k++)
      send(1'b1, 1'b1, 8'd16, 8'd8, k, k == 7, dpat(8'hD8, k), (k == 7) ? 0 : int'($urandom_range(0, 3)));
    chk("s8_enable", out_enable, 1'b1);
    chk("s8_data7", out_data_7, 64'hD807_0123_4567_89AB);
    chk("s8_data0", out_data_0, 64'hD800_0123_4567_89AB);
    chk("s8_ready", in_ready, 1'b0);
    @(negedge clk);
    chk("s8_after_ready", in_ready, 1'b1);
    chk("s8_after_enable", out_enable, 1'b0);

    // Out-of-order index in a size-4 group
    send(1'b0, 1'b1, 8'd4, 8'd4, 0, 1'b0, dpat(8'hC4, 0), 0);
    send(1'b0, 1'b1, 8'd4, 8'd4, 1, 1'b0, dpat(8'hC4, 1), 1);
    send(1'b0, 1'b1, 8'd4, 8'd4, 3, 1'b0, dpat(8'hC4, 3), 0);
    chk("ooo_err_pulse", err_pulse, 1'b1);
    chk("ooo_err_code", err_code, 2'd2);
    chk("ooo_enable", out_enable, 1'b0);
    send(1'b0, 1'b0, 8'd7, 8'd2, 0, 1'b0, dpat(8'hE2, 0), 0);
    send(1'b0, 1'b0, 8'd7, 8'd2, 1, 1'b1, dpat(8'hE2, 1), 0);
    chk("recover_enable", out_enable, 1'b1);
    chk("recover_data1", out_data_1, 64'hE201_0123_4567_89AB);

    // Illegal size, then early last
    send(1'b0, 1'b1, 8'd9, 8'd3, 0, 1'b0, dpat(8'h33, 0), 0);
    chk("ill_err_pulse", err_pulse, 1'b1);
    chk("ill_err_code", err_code, 2'd1);
    chk("ill_ready", in_ready, 1'b1);
    send(1'b0, 1'b1, 8'd9, 8'd2, 0, 1'b1, dpat(8'h22, 0), 0);
    chk("early_err_pulse", err_pulse, 1'b1);
    chk("early_err_code", err_code, 2'd3);
    @(negedge clk);
    chk("err_code_held", err_code, 2'd3);

    // Reset mid-group
    send(1'b1, 1'b0, 8'd12, 8'd4, 0, 1'b0, dpat(8'h44, 0), 0);
    send(1'b1, 1'b0, 8'd12, 8'd4, 1, 1'b0, dpat(8'h44, 1), 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_data0", out_data_0, '0);
    chk("mid_rst_addr", out_rf_addr, 8'd0);
    chk("mid_rst_err_code", err_code, 2'd0);
    send(1'b0, 1'b1, 8'd20, 8'd2, 0, 1'b0, dpat(8'h52, 0), 0);
    send(1'b0, 1'b1, 8'd20, 8'd2, 1, 1'b1, dpat(8'h52, 1), 0);
    chk("post_rst_enable", out_enable, 1'b1);
    chk("post_rst_data1", out_data_1, 64'h5201_0123_4567_89AB);
    chk("post_rst_data2", out_data_2, '0);

    // Back-to-back groups
    send(1'b0, 1'b1, 8'd3, 8'd2, 0, 1'b0, dpat(8'hB1, 0), 0);
    send(1'b0, 1'b1, 8'd3, 8'd2, 1, 1'b1, dpat(8'hB1, 1), 0);
    for (int k = 0; k < 4; k++)
      send(1'b0, 1'b1, 8'd8, 8'd4, k, k == 3, dpat(8'hB2, k), 0);
    chk("b2b_enable", out_enable, 1'b1);
    chk("b2b_addr", out_rf_addr, 8'd8);
    chk("b2b_data1", out_data_1, 64'hB201_0123_4567_89AB);
    chk("b2b_data2", out_data_2, 64'hB202_0123_4567_89AB);
    chk("b2b_data4", out_data_4, '0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
